// File: rtl/alu_serial_deserializer.sv
// Serial packet front end for the ALU core: assembles operands B/A and an opcode, checks count/CRC4/opcode.
// Optional RX_SYNC_EN: 2-flop input synchroniser on sin (adds 2 cycles of latency).
module alu_serial_deserializer #(
  parameter int OP_BYTES = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*OP_BYTES-1:0] out_b,
  output logic [8*OP_BYTES-1:0] out_a,
  output logic [2:0]            out_op,
  output logic [2:0]            out_err,
  output logic                  overrun,
  output logic                  frame_err
);
  localparam int W = 8 * OP_BYTES;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 * OP_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 * OP_BYTES + 1);

  typedef enum logic [2:0] {IDLE, FLAG, PAYLOAD, STOP, RESYNC} state_t;

  state_t           state;
  logic             sin_s;
  logic             is_ctl;
  logic [2:0]       bit_cnt;
  logic [7:0]       pay;
  logic [2*W-1:0]   sr;
  logic [CNT_W-1:0] dcnt;
  logic [3:0]       crc;
  logic [3:0]       crc_data;
  logic [3:0]       crc_ctl;
  logic [2:0]       err_ctl;

`ifdef RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[0], sin};
  end
  assign sin_s = sync[1];
`else
  assign sin_s = sin;
`endif

  // Serial CRC4, polynomial x^4+x+1, one message bit per step
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_comb begin
    crc_data = crc;
    for (int unsigned i = 0; i < 8; i++) crc_data = crc_step(crc_data, pay[3'(7 - i)]);
    crc_ctl = crc_step(crc, 1'b1);
    for (int unsigned i = 0; i < 3; i++) crc_ctl = crc_step(crc_ctl, pay[3'(6 - i)]);
    err_ctl = '0;
    if (dcnt != CNT_FULL)      err_ctl = 3'b100;
    else if (crc_ctl != pay[3:0]) err_ctl = 3'b010;
    else if (pay[5])           err_ctl = 3'b001;  // legal opcodes 000/001/100/101 all have op[1]=0
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_ctl    <= 1'b0;
      bit_cnt   <= '0;
      pay       <= '0;
      sr        <= '0;
      dcnt      <= '0;
      crc       <= '0;
      out_valid <= 1'b0;
      out_b     <= '0;
      out_a     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (!sin_s) state <= FLAG;
        FLAG: begin
          is_ctl  <= sin_s;
          bit_cnt <= '0;
          state   <= PAYLOAD;
        end
        PAYLOAD: begin
          pay     <= {pay[6:0], sin_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: begin
          if (sin_s) begin
            state <= IDLE;
            if (!is_ctl) begin
              sr  <= {sr[2*W-9:0], pay};
              crc <= crc_data;
              if (dcnt != CNT_SAT) dcnt <= dcnt + 1'b1;
            end else begin
              // A commit coinciding with acceptance overrides the clear above
              if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_b     <= sr[2*W-1:W];
                out_a     <= sr[W-1:0];
                out_op    <= pay[6:4];
                out_err   <= err_ctl;
              end else begin
                overrun <= 1'b1;
              end
              dcnt <= '0;
              sr   <= '0;
              crc  <= '0;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= RESYNC;
          end
        end
        RESYNC: if (sin_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_deserializer.sv
// Randomised self-checking bench for alu_serial_deserializer against a queue/polynomial-division model.
module tb_alu_serial_deserializer;
  localparam int OP_BYTES = 4;
  localparam int W = 8 * OP_BYTES;
`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_b;
  logic [W-1:0] out_a;
  logic [2:0]   out_op;
  logic [2:0]   out_err;
  logic         overrun;
  logic         frame_err;

  alu_serial_deserializer #(.OP_BYTES(OP_BYTES), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .out_valid(out_valid), .out_ready(out_ready),
    .out_b(out_b), .out_a(out_a), .out_op(out_op), .out_err(out_err),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: bytes committed since the last CTL and the currently presented record
  logic [7:0]   mbytes[$];
  logic         mvalid = 1'b0;
  logic [W-1:0] mb = '0;
  logic [W-1:0] ma = '0;
  logic [2:0]   mop = '0;
  logic [2:0]   merr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^4 divided by x^4+x+1, M = {bytes, 1, op}
  function automatic logic [3:0] ref_crc(input logic [2:0] op);
    bit r[$];
    int n;
    foreach (mbytes[i]) for (int k = 7; k >= 0; k--) r.push_back(mbytes[i][k]);
    r.push_back(1'b1);
    for (int k = 2; k >= 0; k--) r.push_back(op[k]);
    repeat (4) r.push_back(1'b0);
    n = r.size();
    for (int i = 0; i <= n - 5; i++)
      if (r[i]) begin
        r[i] = 1'b0;
        r[i+3] = r[i+3] ^ 1'b1;
        r[i+4] = r[i+4] ^ 1'b1;
      end
    return {r[n-4], r[n-3], r[n-2], r[n-1]};
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic flag, input logic [7:0] data, input logic stop, input logic rdy);
    send_bit(1'b0);
    send_bit(flag);
    for (int k = 7; k >= 0; k--) send_bit(data[k]);
    sin = stop;
    repeat (LAT) begin @(posedge clk); #1; end
    out_ready = rdy;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("frame_err", {63'd0, frame_err}, {63'd0, ~stop});
  endtask

  task automatic send_data(input logic [7:0] data, input logic stop);
    send_pkt(1'b0, data, stop, 1'b0);
    if (stop) mbytes.push_back(data);
    send_bit(1'b1);
  endtask

  task automatic send_operands(input logic [W-1:0] b, input logic [W-1:0] a);
    for (int i = OP_BYTES - 1; i >= 0; i--) send_data(b[i*8 +: 8], 1'b1);
    for (int i = OP_BYTES - 1; i >= 0; i--) send_data(a[i*8 +: 8], 1'b1);
  endtask

  task automatic send_ctl(input logic [2:0] op, input logic [3:0] crc, input logic rdy);
    logic [63:0] v;
    logic [2:0]  e;
    logic        ovr;
    v = '0;
    foreach (mbytes[i]) v = {v[55:0], mbytes[i]};
    if (mbytes.size() != 2 * OP_BYTES) e = 3'b100;
    else if (ref_crc(op) != crc)       e = 3'b010;
    else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e = 3'b001;
    else                               e = 3'b000;
    ovr = mvalid && !rdy;
    if (!ovr) begin
      mvalid = 1'b1; mb = v[63:32]; ma = v[31:0]; mop = op; merr = e;
    end
    send_pkt(1'b1, {1'b0, op, crc}, 1'b1, rdy);
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, mvalid});
    check_eq("out_b", {32'd0, out_b}, {32'd0, mb});
    check_eq("out_a", {32'd0, out_a}, {32'd0, ma});
    check_eq("out_op", {61'd0, out_op}, {61'd0, mop});
    check_eq("out_err", {61'd0, out_err}, {61'd0, merr});
    check_eq("overrun", {63'd0, overrun}, {63'd0, ovr});
    mbytes.delete();
    send_bit(1'b1);
    check_eq("overrun_pulse", {63'd0, overrun}, 64'd0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    mvalid = 1'b0;
    check_eq("accept_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {out_valid, out_err, out_op, overrun, frame_err}, 64'd0);
    check_eq({tag, "_ab"}, {out_b, out_a}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [3:0] c;
    logic [2:0] ops[4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);

    // Known-answer CRC pass and CRC error
    send_operands(32'h2, 32'h4);
    send_ctl(3'b000, 4'h2, 1'b0);
    check_eq("kat_err", {61'd0, out_err}, 64'd0);
    accept();
    send_operands(32'h2, 32'h4);
    send_ctl(3'b000, 4'hF, 1'b0);
    check_eq("kat_crc_err", {61'd0, out_err}, 64'h2);
    accept();

    // Packet count
    send_data(8'h12, 1'b1);
    send_data(8'h34, 1'b1);
    send_ctl(3'b101, 4'h0, 1'b0);
    accept();
    send_operands($urandom, $urandom);
    send_data(8'h5A, 1'b1);
    send_ctl(3'b100, ref_crc(3'b100), 1'b0);
    accept();
    send_operands(32'hDEADBEEF, 32'h01234567);
    send_ctl(3'b100, ref_crc(3'b100), 1'b0);
    accept();

    // Extremes with every legal opcode, then an illegal opcode with good CRC
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) begin
        send_operands(i == 0 ? '1 : '0, i == 0 ? '1 : '0);
        send_ctl(ops[j], ref_crc(ops[j]), 1'b0);
        accept();
      end
    send_operands(32'h0000FFFF, 32'hA5A5A5A5);
    send_ctl(3'b111, ref_crc(3'b111), 1'b0);
    accept();

    // Handshake: hold, overrun, release; then commit coinciding with acceptance
    send_operands(32'h11111111, 32'h22222222);
    send_ctl(3'b100, ref_crc(3'b100), 1'b0);
    send_operands(32'h33333333, 32'h44444444);
    send_ctl(3'b101, ref_crc(3'b101), 1'b0);
    accept();
    send_operands(32'h55555555, 32'h66666666);
    send_ctl(3'b000, ref_crc(3'b000), 1'b0);
    send_operands(32'h77777777, 32'h88888888);
    send_ctl(3'b001, ref_crc(3'b001), 1'b1);
    accept();

    // Framing: bad DATA stop bit is not counted, bad CTL stop bit loads nothing
    for (int i = 0; i < 4; i++) send_data(8'(i + 1), 1'b1);
    send_data(8'hEE, 1'b0);
    for (int i = 0; i < 4; i++) send_data(8'(i + 9), 1'b1);
    send_ctl(3'b100, ref_crc(3'b100), 1'b0);
    accept();
    send_pkt(1'b1, 8'h42, 1'b0, 1'b0);
    send_bit(1'b1);
    check_eq("frame_ctl_valid", {63'd0, out_valid}, 64'd0);

    // Reset mid-payload with a record pending
    send_operands(32'hCAFEF00D, 32'h0BADC0DE);
    send_ctl(3'b101, ref_crc(3'b101), 1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    mbytes.delete();
    mvalid = 1'b0; mb = '0; ma = '0; mop = '0; merr = '0;
    sin = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (3) send_bit(1'b1);
    send_operands(32'h89ABCDEF, 32'h76543210);
    send_ctl(3'b001, ref_crc(3'b001), 1'b0);
    accept();

    // Randomised traffic: random counts, opcodes, CRC corruption and readiness
    for (int t = 0; t < 40; t++) begin
      int nd;
      nd = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : 2 * OP_BYTES;
      for (int i = 0; i < nd; i++) send_data(8'($urandom), 1'b1);
      op = 3'($urandom);
      c = ref_crc(op);
      if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
      send_ctl(op, c, 1'($urandom));
      if ($urandom_range(0, 1) == 0) accept();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
